button_debouncer: RTL and testbench
===================================

# button_debouncer

Conditions the raw board push-buttons in the `clk30` domain before they reach the LED counter and control logic. Each channel is synchronised, debounced with a fixed hold-off count, and tracked by a four-state FSM. The block outputs a clean level plus single-cycle press, release and long-press strobes. It replaces direct use of raw `button` pins as reset or enable anywhere downstream.

## Interface
- `CLK_FREQ`, default 30000000: `clk30` frequency in Hz.
- `DEBOUNCE_MS`, default 10: stable time required before any state change.
- `LONG_MS`, default 1000: hold time before `long_pulse`.
- `N_BTN`, default 2: number of button channels.
- `clk30  in  1`: system clock. This is the only clock.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `button  in  N_BTN`: raw pins, active-low (0 = pressed), asynchronous to `clk30`.
- `pressed  out  N_BTN`: debounced level, 1 = pressed.
- `press_pulse  out  N_BTN`: 1-cycle strobe on debounced press.
- `release_pulse  out  N_BTN`: 1-cycle strobe on debounced release.
- `long_pulse  out  N_BTN`: 1-cycle strobe, once per press, when the hold reaches `LONG_MS`.

## Operation
- Derived constants:
  - `DB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS`. Default is 300000, which needs a 19-bit counter.
  - `LONG_CYCLES = CLK_FREQ/1000*LONG_MS`. Default is 30000000, which needs a 25-bit counter.
  - Counter widths are `$clog2` of each value. Both values must be at least 2.
- Synchroniser: 2 flops per channel, reset to 1 (released). `s` is the synchronised pressed condition, i.e. sync output == 0.
- FSM per channel, with states RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND:
  - RELEASED: if `s`, go to PRESS_PEND and clear `db_cnt`.
  - PRESS_PEND:
    - If `!s`, return to RELEASED. This is glitch rejection and produces no strobe.
    - Else if `db_cnt == DB_CYCLES-1`, go to PRESSED, clear `hold_cnt`, and clear the `long_done` flag.
    - Else increment `db_cnt`.
  - PRESSED:
    - If `!s`, go to RELEASE_PEND and clear `db_cnt`.
    - Else, while `!long_done`, increment `hold_cnt`. At `LONG_CYCLES-1`, set `long_done` and fire `long_pulse`.
  - RELEASE_PEND:
    - If `s`, return to PRESSED. `hold_cnt` and `long_done` are kept, and no strobe fires.
    - Else if `db_cnt == DB_CYCLES-1`, go to RELEASED.
    - Else increment `db_cnt`. `hold_cnt` is frozen in this state.
- `pressed` is 1 in PRESSED and RELEASE_PEND, and 0 otherwise.
- All strobes are registered and high for exactly the one cycle in which the state change takes effect.
- Channels are fully independent. Simultaneous events on different channels are handled in parallel with no priority.
- Counters never wrap: each is cleared on entry to the state that uses it, and `hold_cnt` stops at `LONG_CYCLES-1`.

## Timing
- Reset (`rst_n` low) takes effect immediately and asynchronously:
  - sync flops go to 1, state goes to RELEASED, counters and `long_done` go to 0;
  - all outputs go to 0.
- Reset asserted mid-press produces no strobe. After release of `rst_n`, a still-held button is re-qualified from RELEASED, giving a fresh `press_pulse`.
- Press latency: `press_pulse` is high on the edge exactly `DB_CYCLES+3` clocks after the first `clk30` edge that samples `button` low. This is 2 sync cycles, 1 cycle to enter PRESS_PEND, and `DB_CYCLES` cycles of counting.
- Release latency is the same: `DB_CYCLES+3`.
- Long press: `long_pulse` fires `LONG_CYCLES` cycles after `press_pulse`, provided there is no bounce. Cycles spent in RELEASE_PEND do not count toward the hold.
- A bounce shorter than `DB_CYCLES` in either direction produces no output change.

## Structure
- Package `button_pkg` holds:
  - the state enum (RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND);
  - a `ms_to_cycles(freq, ms)` function.
- Sub-module `debounce_channel` contains the synchroniser, FSM and counters for one button, with the same parameters minus `N_BTN`.
- The top level is a generate loop over `N_BTN`.

## Test plan
All scenarios use `CLK_FREQ=1000`, `DEBOUNCE_MS=4`, `LONG_MS=10`, which gives `DB_CYCLES=4` and `LONG_CYCLES=10`.
- Clean press: `button[0]` goes low and is held.
  - `press_pulse[0]` is high for exactly 1 cycle, 7 clocks after the sampling edge.
  - `pressed[0]` goes to 1 in the same cycle.
  - `button[1]` outputs stay at 0.
- Glitch: `button[0]` is low for 3 cycles, then high.
  - No strobes fire and `pressed` stays 0 throughout.
- Release bounce: while pressed, `button[0]` goes high for 2 cycles, then low.
  - No `release_pulse` fires, `pressed` stays 1, and `long_pulse` is still delivered once.
- Long hold: `button[0]` is held 40 cycles.
  - `long_pulse[0]` is high exactly once, 10 cycles after `press_pulse`.
  - On release, `release_pulse` fires 7 clocks after the rising edge of `button[0]`.
- Simultaneous events: both buttons are pressed on the same edge.
  - Both `press_pulse` bits fire in the same cycle.
- Reset mid-operation: `rst_n` is pulsed low while in PRESSED.
  - All outputs are 0 immediately.
  - The button is still held, so `press_pulse` recurs 7 clocks after `rst_n` rises.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioning block.
// Holds the per-channel state encoding and the ms-to-cycles conversion.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_e;

    localparam logic [1:0] ST_RELEASED     = RELEASED;
    localparam logic [1:0] ST_PRESS_PEND   = PRESS_PEND;
    localparam logic [1:0] ST_PRESSED      = PRESSED;
    localparam logic [1:0] ST_RELEASE_PEND = RELEASE_PEND;

    function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
        return freq / 1000 * ms;
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Bundle of raw button pins and conditioned outputs, one bit per channel.
// Every output is registered; strobes are high for exactly one clk30 cycle.
interface button_debouncer_if #(
    parameter int unsigned N_BTN = 2
);
    logic [N_BTN-1:0]   button;
    logic [N_BTN-1:0]   pressed;
    logic [N_BTN-1:0]   press_pulse;
    logic [N_BTN-1:0]   release_pulse;
    logic [N_BTN-1:0]   long_pulse;
    logic [2*N_BTN-1:0] state_dbg;

    modport master (
        output button,
        input  pressed, press_pulse, release_pulse, long_pulse, state_dbg
    );

    modport slave (
        input  button,
        output pressed, press_pulse, release_pulse, long_pulse, state_dbg
    );
endinterface

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold-off and long-press counters.
// A state change only happens after the synchronised input has been stable for DB_CYCLES.
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 30000000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic       clk30,
    input  logic       rst_n,
    input  logic       button_n,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [1:0] state_dbg
);

    localparam int unsigned DB_CYCLES   = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYCLES = ms_to_cycles(CLK_FREQ, LONG_MS);
    localparam int unsigned DB_W        = $clog2(DB_CYCLES);
    localparam int unsigned LONG_W      = $clog2(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [1:0]        sync_q, sync_d;
    logic [1:0]        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [LONG_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_done_q, long_done_d;
    logic              pressed_q, pressed_d;
    logic              press_pulse_q, press_pulse_d;
    logic              release_pulse_q, release_pulse_d;
    logic              long_pulse_q, long_pulse_d;
    logic              s;

    // Pin is active-low, so a 0 out of the synchroniser means "pressed".
    assign sync_d = {sync_q[0], button_n};
    assign s      = ~sync_q[1];

    always_comb begin
        state_d         = state_q;
        db_cnt_d        = db_cnt_q;
        hold_cnt_d      = hold_cnt_q;
        long_done_d     = long_done_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (s) begin
                    state_d  = ST_PRESS_PEND;
                    db_cnt_d = '0;
                end
            end
            ST_PRESS_PEND: begin
                if (!s) begin
                    state_d = ST_RELEASED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d       = ST_PRESSED;
                    hold_cnt_d    = '0;
                    long_done_d   = 1'b0;
                    press_pulse_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d  = ST_RELEASE_PEND;
                    db_cnt_d = '0;
                end else if (!long_done_q) begin
                    // hold_cnt parks at its last value once the long press has fired.
                    if (hold_cnt_q == LONG_LAST) begin
                        long_done_d  = 1'b1;
                        long_pulse_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            ST_RELEASE_PEND: begin
                if (s) begin
                    state_d = ST_PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d         = ST_RELEASED;
                    release_pulse_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RELEASED;
            end
        endcase
        pressed_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_PEND);
    end

    always_ff @(posedge clk30 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q          <= 2'b11;
            state_q         <= ST_RELEASED;
            db_cnt_q        <= '0;
            hold_cnt_q      <= '0;
            long_done_q     <= 1'b0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            db_cnt_q        <= db_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            long_done_q     <= long_done_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign state_dbg     = state_q;

endmodule

// File: rtl/button_debouncer.sv
// Conditions N_BTN raw active-low push-buttons into clean levels and event strobes.
// Channels are fully independent copies of debounce_channel.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 30000000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned N_BTN       = 2
) (
    input  logic              clk30,
    input  logic              rst_n,
    button_debouncer_if.slave bus
);

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
        debounce_channel #(
            .CLK_FREQ    (CLK_FREQ),
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS)
        ) u_ch (
            .clk30         (clk30),
            .rst_n         (rst_n),
            .button_n      (bus.button[i]),
            .pressed       (bus.pressed[i]),
            .press_pulse   (bus.press_pulse[i]),
            .release_pulse (bus.release_pulse[i]),
            .long_pulse    (bus.long_pulse[i]),
            .state_dbg     (bus.state_dbg[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bouncing, checked
// cycle by cycle against a stability-window model through an expected queue.
module tb_button_debouncer;

    localparam int unsigned CLK_FREQ    = 1000;
    localparam int unsigned DEBOUNCE_MS = 4;
    localparam int unsigned LONG_MS     = 10;
    localparam int unsigned N           = 2;
    localparam int DB   = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int LC   = CLK_FREQ / 1000 * LONG_MS;
    localparam int OBSW = 4 * N;

    logic clk30;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   started = 0;

    button_debouncer_if #(.N_BTN(N)) bus ();

    button_debouncer #(
        .CLK_FREQ    (CLK_FREQ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .LONG_MS     (LONG_MS),
        .N_BTN       (N)
    ) dut (
        .clk30 (clk30),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk30 = 1'b0;
    always #5 clk30 = ~clk30;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Debounced level flips once the synchronised input (pin delayed by two
    // samples) has disagreed with it for DB+1 consecutive samples.  The hold
    // time counts samples where the level is pressed and the input agrees
    // with it without an open disagreement run.
    logic [OBSW-1:0] exp_q[$];
    logic [N-1:0]    raw_q[$];
    bit              m_level[N];
    int              m_run[N];
    int              m_hold[N];
    bit              m_ldone[N];

    task automatic model_step();
        logic [N-1:0] raw;
        logic [N-1:0] e_pr, e_ps, e_rl, e_lg;
        bit           s;
        e_pr = '0; e_ps = '0; e_rl = '0; e_lg = '0;
        if (!rst_n) begin
            raw_q.delete();
            raw_q.push_back('1);
            raw_q.push_back('1);
            for (int c = 0; c < N; c++) begin
                m_level[c] = 0; m_run[c] = 0; m_hold[c] = 0; m_ldone[c] = 0;
            end
        end else begin
            raw = raw_q.pop_front();
            raw_q.push_back(bus.button);
            for (int c = 0; c < N; c++) begin
                s = !raw[c];
                if (s != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB + 1) begin
                        m_level[c] = s;
                        m_run[c]   = 0;
                        if (s) begin
                            e_ps[c] = 1'b1; m_hold[c] = 0; m_ldone[c] = 0;
                        end else begin
                            e_rl[c] = 1'b1;
                        end
                    end
                end else begin
                    if (m_level[c] && m_run[c] == 0 && !m_ldone[c]) begin
                        m_hold[c]++;
                        if (m_hold[c] == LC) begin
                            m_ldone[c] = 1; e_lg[c] = 1'b1;
                        end
                    end
                    m_run[c] = 0;
                end
                e_pr[c] = m_level[c];
            end
        end
        exp_q.push_back({e_pr, e_ps, e_rl, e_lg});
    endtask

    always @(posedge clk30) begin
        model_step();
        started = 1;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk30) begin
        logic [OBSW-1:0] e, a;
        if (started) begin
            n_tests++;
            a = {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL outputs @%0t: no expected entry, got %b", $time, a);
            end else begin
                e = exp_q.pop_front();
                if (!rst_n) e = '0;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got pressed=%b press=%b release=%b long=%b, expected pressed=%b press=%b release=%b long=%b",
                             $time, a[4*N-1 -: N], a[3*N-1 -: N], a[2*N-1 -: N], a[N-1:0],
                             e[4*N-1 -: N], e[3*N-1 -: N], e[2*N-1 -: N], e[N-1:0]);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    function automatic logic [N-1:0] strobe_sel(input int sel);
        case (sel)
            0:       return bus.press_pulse;
            1:       return bus.release_pulse;
            default: return bus.long_pulse;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk30);
        #2;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Counts clock edges until the selected strobe is seen; returns at posedge+2.
    task automatic count_until(input int sel, input int ch, input int limit, input int want, input string name);
        int           n;
        bit           hit;
        logic [N-1:0] v;
        n = 0; hit = 0;
        while (!hit && n < limit) begin
            @(posedge clk30); #1;
            n++;
            v = strobe_sel(sel);
            if (v[ch]) hit = 1;
        end
        if (!hit) n = -1;
        check_int(name, n, want);
        #1;
    endtask

    task automatic watch0(input int cycles, output int np, output int nr, output int nl, output int nh);
        np = 0; nr = 0; nl = 0; nh = 0;
        repeat (cycles) begin
            @(posedge clk30); #1;
            np += int'(bus.press_pulse[0]);
            nr += int'(bus.release_pulse[0]);
            nl += int'(bus.long_pulse[0]);
            nh += int'(bus.pressed[0]);
        end
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        logic [OBSW-1:0] a;
        a = {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse};
        n_tests++;
        if (a !== '0) begin
            n_fail++;
            $display("FAIL %s: got outputs %b, expected all zero", name, a);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int np, nr, nl, nh;
        int tmr[N];
        bus.button = '1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk30);
        #1;
        check_outputs_zero("reset_state");
        #1;
        rst_n = 1'b1;
        step(3);

        // clean press, long press and release on channel 0
        bus.button[0] = 1'b0;
        count_until(0, 0, 20, DB + 3, "press_latency");
        count_until(2, 0, 30, LC, "long_latency");
        step(20);
        bus.button[0] = 1'b1;
        count_until(1, 0, 20, DB + 3, "release_latency");
        step(10);

        // glitch shorter than the hold-off
        bus.button[0] = 1'b0;
        step(3);
        bus.button[0] = 1'b1;
        watch0(15, np, nr, nl, nh);
        check_int("glitch_quiet", np + nr + nl + nh, 0);

        // release bounce while pressed
        bus.button[0] = 1'b0;
        count_until(0, 0, 20, DB + 3, "bounce_press");
        #1;
        step(3);
        bus.button[0] = 1'b1;
        step(2);
        bus.button[0] = 1'b0;
        watch0(40, np, nr, nl, nh);
        check_int("bounce_no_release", nr, 0);
        check_int("bounce_long_once", nl, 1);
        check_int("bounce_pressed_held", nh, 40);
        bus.button[0] = 1'b1;
        step(12);

        // simultaneous press on both channels, then reset mid-press
        bus.button = '0;
        count_until(0, 0, 20, DB + 3, "simul_press_latency");
        check_int("simul_both", int'(bus.press_pulse), (1 << N) - 1);
        step(4);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_outputs");
        repeat (2) @(posedge clk30);
        #2;
        rst_n = 1'b1;
        count_until(0, 0, 20, DB + 3, "reset_repress");
        step(5);
        bus.button = '1;
        step(12);

        // random bouncing on both channels
        for (int c = 0; c < N; c++) tmr[c] = $urandom_range(1, 8);
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (tmr[c] == 0) begin
                    bus.button[c] = ~bus.button[c];
                    tmr[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 30) : $urandom_range(1, 8);
                end else begin
                    tmr[c]--;
                end
            end
            step(1);
        end
        bus.button = '1;
        step(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
